// File: rtl/watchdog_timer_ctrl.sv
// rtl/watchdog_timer_ctrl.sv - test watchdog down-counter with round-robin kick crediting
// Expiry raises a sticky flag for the bench-side watchdog; honoured kicks reload from the latched limit.
module watchdog_timer_ctrl #(
   parameter  int COUNTER_WIDTH = 32,
   parameter  int NUM_AGENTS    = 4,
   localparam int AGENT_W       = $clog2(NUM_AGENTS)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [COUNTER_WIDTH-1:0] timeout_count,
   input  logic                     load,
   input  logic                     clear,
   input  logic [NUM_AGENTS-1:0]    kick,
   input  logic [NUM_AGENTS-1:0]    kick_mask,
   output logic                     hdl_timeout,
   output logic [COUNTER_WIDTH-1:0] count_remaining,
   output logic                     kick_valid,
   output logic [AGENT_W-1:0]       last_kicker,
   output logic [7:0]               expire_count,
   output logic                     armed
);

   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_EXPIRED} state_t;

   state_t                   r_state, w_state_nxt;
   logic [COUNTER_WIDTH-1:0] r_limit, w_limit_nxt;
   logic [COUNTER_WIDTH-1:0] r_count, w_count_nxt;
   logic                     r_timeout, w_timeout_nxt;
   logic                     r_kick_valid, w_kick_valid_nxt;
   logic [AGENT_W-1:0]       r_last_kicker, w_last_kicker_nxt;
   logic [7:0]               r_expire_count, w_expire_count_nxt;
   logic [AGENT_W-1:0]       r_ptr, w_ptr_nxt;

   logic [NUM_AGENTS-1:0]    w_honoured;
   logic                     w_win_found;
   logic [AGENT_W-1:0]       w_winner;
   logic                     w_tc_zero;
   int                       w_idx;

   assign w_honoured = kick & kick_mask;
   assign w_tc_zero  = (timeout_count == '0);

   // Scan from the pointer upward, wrapping, so the last credited agent goes to the back of the line.
   always_comb begin
      w_win_found = 1'b0;
      w_winner    = '0;
      w_idx       = 0;
      for (int i = 0; i < NUM_AGENTS; i++) begin
         w_idx = (int'(r_ptr) + i) % NUM_AGENTS;
         if (!w_win_found && w_honoured[w_idx]) begin
            w_win_found = 1'b1;
            w_winner    = AGENT_W'(w_idx);
         end
      end
   end

   always_comb begin
      w_state_nxt        = r_state;
      w_limit_nxt        = r_limit;
      w_count_nxt        = r_count;
      w_timeout_nxt      = r_timeout;
      w_kick_valid_nxt   = 1'b0;
      w_last_kicker_nxt  = r_last_kicker;
      w_expire_count_nxt = r_expire_count;
      w_ptr_nxt          = r_ptr;
      case (r_state)
         ST_IDLE: begin
            if (load && !w_tc_zero) begin
               w_limit_nxt = timeout_count;
               w_count_nxt = timeout_count;
               w_state_nxt = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (load) begin
               if (w_tc_zero) begin
                  w_count_nxt = '0;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_limit_nxt = timeout_count;
                  w_count_nxt = timeout_count;
               end
            end else if (w_win_found) begin
               // A kick on the final count wins over expiry.
               w_count_nxt       = r_limit;
               w_kick_valid_nxt  = 1'b1;
               w_last_kicker_nxt = w_winner;
               w_ptr_nxt         = (w_winner == AGENT_W'(NUM_AGENTS - 1)) ? '0 : w_winner + 1'b1;
            end else if (r_count == COUNTER_WIDTH'(1)) begin
               w_count_nxt        = '0;
               w_timeout_nxt      = 1'b1;
               w_expire_count_nxt = (r_expire_count == 8'hFF) ? r_expire_count : r_expire_count + 8'd1;
               w_state_nxt        = ST_EXPIRED;
            end else begin
               w_count_nxt = r_count - 1'b1;
            end
         end
         ST_EXPIRED: begin
            if (load) begin
               w_timeout_nxt = 1'b0;
               if (w_tc_zero) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_limit_nxt = timeout_count;
                  w_count_nxt = timeout_count;
                  w_state_nxt = ST_ARMED;
               end
            end else if (clear) begin
               w_timeout_nxt = 1'b0;
               w_state_nxt   = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= ST_IDLE;
         r_limit        <= '0;
         r_count        <= '0;
         r_timeout      <= 1'b0;
         r_kick_valid   <= 1'b0;
         r_last_kicker  <= '0;
         r_expire_count <= '0;
         r_ptr          <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_limit        <= w_limit_nxt;
         r_count        <= w_count_nxt;
         r_timeout      <= w_timeout_nxt;
         r_kick_valid   <= w_kick_valid_nxt;
         r_last_kicker  <= w_last_kicker_nxt;
         r_expire_count <= w_expire_count_nxt;
         r_ptr          <= w_ptr_nxt;
      end
   end

   assign hdl_timeout     = r_timeout;
   assign count_remaining = r_count;
   assign kick_valid      = r_kick_valid;
   assign last_kicker     = r_last_kicker;
   assign expire_count    = r_expire_count;
   assign armed           = (r_state == ST_ARMED);

endmodule

// File: doc/watchdog_timer_ctrl.md
Name: watchdog_timer_ctrl

Overview:
HDL-side controller for the test watchdog. It latches a timeout limit from the verification side and arms a down-counter. Heartbeat kicks from up to NUM_AGENTS requesters reload the counter; a round-robin arbiter records which agent was credited. If the counter runs out, it asserts a sticky hdl_timeout flag that the testbench watchdog component samples to shut the test down.

Parameters:
COUNTER_WIDTH, 32, width of timeout limit and down-counter
NUM_AGENTS, 4, number of kick requesters (2..16)
AGENT_W, $clog2(NUM_AGENTS), width of agent index (derived, not overridable)

Ports:
clk  input  1  single clock; all state changes on rising edge
reset_n  input  1  asynchronous active-low reset
timeout_count  input  COUNTER_WIDTH  limit to load, in clk cycles
load  input  1  pulse; latch timeout_count and arm (0 = disarm)
clear  input  1  pulse; leave EXPIRED, return to IDLE
kick  input  NUM_AGENTS  per-agent heartbeat, one bit per agent
kick_mask  input  NUM_AGENTS  1 = agent's kicks honoured
hdl_timeout  output  1  sticky expiry flag, active high
count_remaining  output  COUNTER_WIDTH  current down-counter value
kick_valid  output  1  one-cycle pulse: an honoured kick reloaded the counter
last_kicker  output  AGENT_W  index of most recent credited agent
expire_count  output  8  number of expiries since reset, saturating at 255
armed  output  1  high in ARMED state

Behaviour:
- Reset (async assert, sync release): state IDLE; limit=0; count_remaining=0; hdl_timeout=0; kick_valid=0; last_kicker=0; expire_count=0; armed=0; RR pointer=0.
- States are IDLE, ARMED and EXPIRED. All outputs are registered.
- Event priority each cycle: load > clear > kick > decrement.
- IDLE:
  - load with timeout_count!=0: limit<=timeout_count; count<=timeout_count; go to ARMED.
  - load with 0: stay in IDLE.
  - kick and clear are ignored.
- ARMED:
  - load: limit and count <= timeout_count, or go to IDLE with count=0 if the value is 0.
  - else any honoured kick (kick & kick_mask != 0): count<=limit; kick_valid=1 next cycle; last_kicker<=RR winner.
  - else count==1: count<=0; hdl_timeout<=1; expire_count+=1 (saturating); go to EXPIRED.
  - else count<=count-1.
  - clear is ignored in ARMED.
- EXPIRED:
  - hdl_timeout held at 1; kicks ignored; count stays 0.
  - clear: go to IDLE, hdl_timeout<=0.
  - load (nonzero): go to ARMED directly, hdl_timeout<=0, count<=timeout_count.
  - load with 0: go to IDLE, hdl_timeout<=0.
- Latency: with no kicks, load at edge E gives count=L after E, and hdl_timeout rises after edge E+L (exactly L cycles later).
- A kick at the same edge count would reach 1→0 wins: counter reloads, no expiry.
- Round-robin arbitration:
  - Winner is the first honoured bit at index >= pointer, wrapping modulo NUM_AGENTS.
  - After each grant, pointer <= (winner+1) mod NUM_AGENTS.
  - Pointer changes only on a credited kick.
- A masked kick has no effect on counter, kick_valid or arbitration.
- The counter never wraps below 0; a limit of all-ones is legal and counts the full range.
- Reset asserted mid-operation returns every output to its reset value immediately.

Test Plan:
- Arm and expire: load timeout_count=10, no kicks → hdl_timeout rises exactly 10 cycles after load edge; expire_count=1; armed=0.
- Kick reload: load 8, kick[2] at cycles 5 and 11 → count reloads to 8 each time; kick_valid pulses twice; last_kicker=2; expiry 8 cycles after final kick.
- Round-robin: load 100; hold kick=4'b1011 for 4 cycles → last_kicker sequence 0,1,3,0.
- Masking and boundary: kick_mask=4'b0000, kick=4'b1111 → counter still expires. Separately, kick at the cycle count==1 → no expiry, count=limit.
- Priority and sticky flag: in EXPIRED, kick → no change; clear → IDLE, hdl_timeout=0. Load 0 while ARMED → IDLE. Load 5 in EXPIRED → ARMED, count=5.
- Saturation and reset: 256 load/expire cycles → expire_count=255. Assert reset_n=0 while ARMED with count=50 → all outputs 0 asynchronously.
